// File: rtl/pio_bus_pkg.sv
// Shared types and defaults for the parallel I/O bus master/arbiter.
// Holds the access-phase enum, default widths/timings and the counter sizing helper.
package pio_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } pio_state_t;

    localparam int PIO_ADDR_W     = 2;
    localparam int PIO_DATA_W     = 8;
    localparam int PIO_SETUP_CYC  = 1;
    localparam int PIO_STROBE_CYC = 2;
    localparam int PIO_HOLD_CYC   = 1;

    // Width needed to hold max(s, t, h); never narrower than one bit.
    function automatic int pio_cnt_w(input int s, input int t, input int h);
        int m;
        m = s;
        if (t > m) m = t;
        if (h > m) m = h;
        if (m < 1) return 1;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pio_rr_arb.sv
// Two-way round-robin arbiter; owns the last-grant history bit.
// On a tie the requester not served most recently wins.
module pio_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_grant;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (en && gnt_valid) begin
            last_grant <= gnt_idx;
        end
    end

endmodule

// File: rtl/pio_bus_arbiter.sv
// Bus master for the 8-bit parallel I/O peripheral, shared by two requesters.
// Each granted request becomes one registered setup/strobe/hold access followed by an ack.
module pio_bus_arbiter
    import pio_bus_pkg::*;
#(
    parameter int SETUP_CYC  = PIO_SETUP_CYC,
    parameter int STROBE_CYC = PIO_STROBE_CYC,
    parameter int HOLD_CYC   = PIO_HOLD_CYC,
    parameter int ADDR_W     = PIO_ADDR_W,
    parameter int DATA_W     = PIO_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt,
    output logic              cs_n,
    output logic              we_n,
    output logic              oe_n,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_tx,
    input  logic [DATA_W-1:0] data_rx
);

    generate
        if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_timing
            $error("pio_bus_arbiter: SETUP_CYC, STROBE_CYC and HOLD_CYC must all be >= 1");
        end
    endgenerate

    localparam int CW = pio_cnt_w(SETUP_CYC, STROBE_CYC, HOLD_CYC);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);

    pio_state_t    state;
    pio_state_t    state_n;
    logic [CW-1:0] cnt;
    logic          we_l;
    logic          gnt_valid;
    logic          gnt_idx;
    logic          grant;
    logic          last_phase;

    assign grant      = (state == ST_IDLE) && gnt_valid;
    assign last_phase = (cnt == '0);

    pio_rr_arb u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1, req0}),
        .en        (state == ST_IDLE),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (gnt_valid)  state_n = ST_SETUP;
            ST_SETUP:  if (last_phase) state_n = ST_STROBE;
            ST_STROBE: if (last_phase) state_n = ST_HOLD;
            ST_HOLD:   if (last_phase) state_n = ST_DONE;
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            // Phase counter is reloaded on every state entry and counts down to zero.
            if (state_n != state) begin
                case (state_n)
                    ST_SETUP:  cnt <= SETUP_LD;
                    ST_STROBE: cnt <= STROBE_LD;
                    ST_HOLD:   cnt <= HOLD_LD;
                    default:   cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Transaction fields are captured at grant so later requester changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt     <= 1'b0;
            we_l    <= 1'b0;
            addr    <= '0;
            data_tx <= '0;
        end else if (grant) begin
            gnt     <= gnt_idx;
            we_l    <= gnt_idx ? we1 : we0;
            addr    <= gnt_idx ? addr1 : addr0;
            data_tx <= gnt_idx ? wdata1 : wdata0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (state == ST_STROBE && last_phase && !we_l) begin
            rdata <= data_rx;
        end
    end

    // Strobes, busy and acks are decoded from the next state so they change with the phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n <= 1'b1;
            we_n <= 1'b1;
            oe_n <= 1'b1;
            busy <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
        end else begin
            cs_n <= (state_n != ST_STROBE);
            we_n <= !((state_n == ST_STROBE) && we_l);
            oe_n <= !((state_n == ST_STROBE) && !we_l);
            busy <= (state_n != ST_IDLE);
            ack0 <= (state_n == ST_DONE) && !gnt;
            ack1 <= (state_n == ST_DONE) && gnt;
        end
    end

endmodule

// File: tb/tb_pio_bus_arbiter.sv
// Directed self-checking bench for pio_bus_arbiter: default timing instance plus a 2/3/2 variant.
module tb_pio_bus_arbiter;

    logic       clk;
    logic       rst;

    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy, gnt, cs_n, we_n, oe_n;
    logic [7:0] rdata, data_tx, data_rx;
    logic [1:0] addr;

    logic       b_req0, b_req1, b_we0, b_we1;
    logic [1:0] b_addr0, b_addr1;
    logic [7:0] b_wdata0, b_wdata1;
    logic       b_ack0, b_ack1, b_busy, b_gnt, b_cs_n, b_we_n, b_oe_n;
    logic [7:0] b_rdata, b_data_tx, b_data_rx;
    logic [1:0] b_addr;

    int n_tests;
    int n_fail;

    pio_bus_arbiter u_dut (
        .clk(clk), .reset(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .gnt(gnt),
        .cs_n(cs_n), .we_n(we_n), .oe_n(oe_n), .addr(addr),
        .data_tx(data_tx), .data_rx(data_rx)
    );

    pio_bus_arbiter #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) u_dut_b (
        .clk(clk), .reset(rst),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy), .gnt(b_gnt),
        .cs_n(b_cs_n), .we_n(b_we_n), .oe_n(b_oe_n), .addr(b_addr),
        .data_tx(b_data_tx), .data_rx(b_data_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on the default instance; cycle k=0 is the cycle starting at E0.
    task automatic access_a(input bit r, input bit w, input logic [1:0] a,
                            input logic [7:0] wd, input logic [7:0] rx, input string tag);
        logic [5:0] strb;
        logic [5:0] ackv;
        logic [5:0] busyv;
        strb  = 6'b000110;
        ackv  = 6'b010000;
        busyv = 6'b011111;
        data_rx = rx;
        if (!r) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = wd;
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = wd;
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 0) begin
                if (!r) begin
                    we0 = ~w; addr0 = ~a; wdata0 = ~wd;
                end else begin
                    we1 = ~w; addr1 = ~a; wdata1 = ~wd;
                end
            end
            check({tag, "/cs_n"}, cs_n, !strb[k]);
            check({tag, "/we_n"}, we_n, w ? !strb[k] : 1'b1);
            check({tag, "/oe_n"}, oe_n, w ? 1'b1 : !strb[k]);
            check({tag, "/ack0"}, ack0, !r && ackv[k]);
            check({tag, "/ack1"}, ack1, r && ackv[k]);
            check({tag, "/busy"}, busy, busyv[k]);
            check({tag, "/addr"}, addr, a);
            check({tag, "/data_tx"}, data_tx, wd);
            check({tag, "/gnt"}, gnt, r);
            if (!w && k >= 4) check({tag, "/rdata"}, rdata, rx);
            if (k == 4) begin
                if (!r) req0 = 1'b0;
                else    req1 = 1'b0;
            end
        end
    endtask

    initial begin
        bit         found;
        int         gap;
        logic [3:0] order;
        logic [8:0] strb2;
        logic [8:0] ack2;
        logic [8:0] busy2;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; data_rx = '0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0; b_addr0 = '0; b_addr1 = '0;
        b_wdata0 = '0; b_wdata1 = '0; b_data_rx = '0;

        tick();
        tick();
        check("rst/cs_n", cs_n, 1'b1);
        check("rst/we_n", we_n, 1'b1);
        check("rst/oe_n", oe_n, 1'b1);
        check("rst/addr", addr, 2'd0);
        check("rst/data_tx", data_tx, 8'h00);
        check("rst/rdata", rdata, 8'h00);
        check("rst/ack0", ack0, 1'b0);
        check("rst/ack1", ack1, 1'b0);
        check("rst/busy", busy, 1'b0);
        check("rst/gnt", gnt, 1'b0);
        check("rst/b_cs_n", b_cs_n, 1'b1);
        check("rst/b_busy", b_busy, 1'b0);
        rst = 1'b0;

        // Async reset during the second STROBE cycle of a write.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h5A;
        tick();
        check("abort/setup_busy", busy, 1'b1);
        tick();
        tick();
        check("abort/strobe2_cs_n", cs_n, 1'b0);
        check("abort/strobe2_we_n", we_n, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("abort/cs_n", cs_n, 1'b1);
        check("abort/we_n", we_n, 1'b1);
        check("abort/busy", busy, 1'b0);
        check("abort/addr", addr, 2'd0);
        check("abort/data_tx", data_tx, 8'h00);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort/no_ack0", ack0, 1'b0);
        end
        rst = 1'b0;
        access_a(1'b0, 1'b1, 2'd3, 8'h5A, 8'h00, "rearb");

        access_a(1'b0, 1'b1, 2'd0, 8'hFF, 8'h00, "wr");
        check("rd/rdata_before", rdata, 8'h00);
        access_a(1'b1, 1'b0, 2'd1, 8'h00, 8'hA5, "rd");
        access_a(1'b0, 1'b1, 2'd2, 8'h77, 8'h3C, "wr2");
        check("wr2/rdata_kept", rdata, 8'hA5);

        // Tie alternation after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        order = 4'b1010;
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b1; addr1 = 2'd3; wdata1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick();
                if (ack0 || ack1) begin
                    found = 1'b1;
                    break;
                end
            end
            check("tie/ack_seen", found, 1'b1);
            check("tie/both_acks", ack0 && ack1, 1'b0);
            check("tie/ack1", ack1, order[i]);
            check("tie/gnt", gnt, order[i]);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();

        // Back-to-back single requester.
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'h42;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ack0) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b/first_ack", found, 1'b1);
        for (int i = 0; i < 3; i++) begin
            gap = 0;
            for (int c = 0; c < 20; c++) begin
                tick();
                gap++;
                check("b2b/no_ack1", ack1, 1'b0);
                if (ack0) break;
            end
            check("b2b/spacing", gap, 6);
            check("b2b/gnt", gnt, 1'b0);
        end
        req0 = 1'b0;
        tick();
        tick();

        // Variant instance 2/3/2: read by requester 1.
        strb2 = 9'b000011100;
        ack2  = 9'b010000000;
        busy2 = 9'b011111111;
        b_req1 = 1'b1; b_we1 = 1'b0; b_addr1 = 2'd2; b_data_rx = 8'hC3;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("var/cs_n", b_cs_n, !strb2[k]);
            check("var/oe_n", b_oe_n, !strb2[k]);
            check("var/we_n", b_we_n, 1'b1);
            check("var/ack1", b_ack1, ack2[k]);
            check("var/ack0", b_ack0, 1'b0);
            check("var/busy", b_busy, busy2[k]);
            check("var/addr", b_addr, 2'd2);
            if (k == 7) begin
                check("var/rdata", b_rdata, 8'hC3);
                b_req1 = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
